inst_cache: RTL and testbench

- Non-blocking, direct-mapped, read-only instruction cache between the IF stage and unified memory.
- Toward IF it presents the same tagged request/response protocol that memory uses, so IF needs no change when the cache is inserted.
- Misses are tracked in a small MSHR file and forwarded to memory one per cycle; returned blocks fill the cache and go back to IF under cache-generated tags.

---
 rtl/inst_cache_if.sv | 31 +++
 rtl/inst_cache.sv | 162 ++++++++++++++++
 tb/tb_inst_cache.sv | 136 +++++++++++++
 3 files changed

// File: rtl/inst_cache_if.sv
// Bus bundle shared by the IF stage, the instruction cache and unified memory.
// The cache uses the slave view; the fetch/memory side uses the master view.
interface inst_cache_if #(
    parameter int XLEN = 64
);
    logic [1:0]      proc2cache_command_i;
    logic [XLEN-1:0] proc2cache_addr_i;
    logic [3:0]      cache2proc_response_o;
    logic [63:0]     cache2proc_data_o;
    logic [3:0]      cache2proc_tag_o;
    logic            memory_enable_i;
    logic [1:0]      cache2mem_command_o;
    logic [XLEN-1:0] cache2mem_addr_o;
    logic [3:0]      mem2cache_response_i;
    logic [63:0]     mem2cache_data_i;
    logic [3:0]      mem2cache_tag_i;

    modport slave (
        input  proc2cache_command_i, proc2cache_addr_i, memory_enable_i,
        input  mem2cache_response_i, mem2cache_data_i, mem2cache_tag_i,
        output cache2proc_response_o, cache2proc_data_o, cache2proc_tag_o,
        output cache2mem_command_o, cache2mem_addr_o
    );

    modport master (
        output proc2cache_command_i, proc2cache_addr_i, memory_enable_i,
        output mem2cache_response_i, mem2cache_data_i, mem2cache_tag_i,
        input  cache2proc_response_o, cache2proc_data_o, cache2proc_tag_o,
        input  cache2mem_command_o, cache2mem_addr_o
    );
endinterface

// File: rtl/inst_cache.sv
// Non-blocking direct-mapped instruction cache with an MSHR file; the fetch
// side sees the same tagged request/response protocol that memory provides.
//
// state      | meaning
// INVALID    | entry free, may be allocated
// WAIT_ISSUE | miss recorded, waiting for memory to accept the request
// WAIT_MEM   | request accepted under mem_tag, waiting for fill data
// READY      | data held, waiting to be returned to IF
module inst_cache #(
    parameter int CACHE_LINES = 32,
    parameter int MSHR_NUM    = 8,
    parameter int XLEN        = 64
) (
    input logic         clk_i,
    input logic         rst_i,
    inst_cache_if.slave bus
);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = XLEN - 3 - IDX_W;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {INVALID, WAIT_ISSUE, WAIT_MEM, READY} mshr_state_t;

    mshr_state_t     state_q [MSHR_NUM];
    mshr_state_t     state_d [MSHR_NUM];
    logic [XLEN-1:0] addr_q  [MSHR_NUM];
    logic [XLEN-1:0] addr_d  [MSHR_NUM];
    logic [3:0]      mtag_q  [MSHR_NUM];
    logic [3:0]      mtag_d  [MSHR_NUM];
    logic [63:0]     data_q  [MSHR_NUM];
    logic [63:0]     data_d  [MSHR_NUM];

    logic [CACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]       line_tag  [CACHE_LINES];
    logic [63:0]            line_data [CACHE_LINES];

    logic             rst_q;
    logic             blocked;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_hit;
    logic             fill_en;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             alloc_done;
    logic             issue_done;
    logic             ret_done;
    logic [3:0]       resp;
    logic [1:0]       mem_cmd;
    logic [XLEN-1:0]  mem_addr;
    logic [3:0]       ret_tag;
    logic [63:0]      ret_data;
    logic             unused_offset;

    // Whole blocks are returned, so the byte offset plays no part.
    assign unused_offset = ^bus.proc2cache_addr_i[2:0];

    // Outputs stay quiet during reset and for one cycle after it.
    assign blocked = rst_i | rst_q;

    assign req_idx = bus.proc2cache_addr_i[3 +: IDX_W];
    assign req_tag = bus.proc2cache_addr_i[XLEN-1 -: TAG_W];
    assign req_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mtag_d     = mtag_q;
        data_d     = data_q;
        resp       = '0;
        mem_cmd    = BUS_NONE;
        mem_addr   = '0;
        ret_tag    = '0;
        ret_data   = '0;
        fill_en    = 1'b0;
        fill_idx   = '0;
        fill_tag   = '0;
        alloc_done = 1'b0;
        issue_done = 1'b0;
        ret_done   = 1'b0;
        // Each entry is in exactly one state, so allocate/issue/fill/return
        // always land on different entries.
        for (int i = 0; i < MSHR_NUM; i++) begin
            case (state_q[i])
                INVALID: begin
                    if (!alloc_done && !blocked && bus.proc2cache_command_i == BUS_LOAD) begin
                        alloc_done = 1'b1;
                        resp       = 4'(i + 1);
                        addr_d[i]  = {bus.proc2cache_addr_i[XLEN-1:3], 3'b000};
                        if (req_hit) begin
                            state_d[i] = READY;
                            data_d[i]  = line_data[req_idx];
                        end else begin
                            state_d[i] = WAIT_ISSUE;
                        end
                    end
                end
                WAIT_ISSUE: begin
                    if (!issue_done && !blocked && bus.memory_enable_i) begin
                        issue_done = 1'b1;
                        mem_cmd    = BUS_LOAD;
                        mem_addr   = addr_q[i];
                        if (bus.mem2cache_response_i != 4'd0) begin
                            mtag_d[i]  = bus.mem2cache_response_i;
                            state_d[i] = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (!fill_en && bus.mem2cache_tag_i != 4'd0 && bus.mem2cache_tag_i == mtag_q[i]) begin
                        fill_en    = 1'b1;
                        fill_idx   = addr_q[i][3 +: IDX_W];
                        fill_tag   = addr_q[i][XLEN-1 -: TAG_W];
                        data_d[i]  = bus.mem2cache_data_i;
                        state_d[i] = READY;
                    end
                end
                READY: begin
                    if (!ret_done && !blocked) begin
                        ret_done   = 1'b1;
                        ret_tag    = 4'(i + 1);
                        ret_data   = data_q[i];
                        state_d[i] = INVALID;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        rst_q <= rst_i;
        if (rst_i) begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                state_q[i] <= INVALID;
            end
            line_valid <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                line_valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        mtag_q <= mtag_d;
        data_q <= data_d;
        if (fill_en) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= bus.mem2cache_data_i;
        end
    end

    assign bus.cache2proc_response_o = resp;
    assign bus.cache2proc_tag_o      = ret_tag;
    assign bus.cache2proc_data_o     = ret_data;
    assign bus.cache2mem_command_o   = mem_cmd;
    assign bus.cache2mem_addr_o      = mem_addr;
endmodule

// File: tb/tb_inst_cache.sv
// Directed cycle-by-cycle bench for inst_cache: each vector is one clock cycle
// of inputs plus the combinational outputs expected in that same cycle.
module tb_inst_cache;
    localparam logic [1:0] NO = 2'd0;
    localparam logic [1:0] LD = 2'd1;
    localparam logic [1:0] ST = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inst_cache_if #(.XLEN(64)) bus ();

    inst_cache #(.CACHE_LINES(32), .MSHR_NUM(8), .XLEN(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic        en;
        logic [3:0]  mresp;
        logic [3:0]  mtag;
        logic [63:0] mdata;
        logic [3:0]  e_resp;
        logic [3:0]  e_ptag;
        logic [63:0] e_pdata;
        logic [1:0]  e_mcmd;
        logic [63:0] e_maddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] cmd, input logic [63:0] addr, input logic en,
                                input logic [3:0] mresp, input logic [3:0] mtag, input logic [63:0] mdata,
                                input logic [3:0] e_resp, input logic [3:0] e_ptag, input logic [63:0] e_pdata,
                                input logic [1:0] e_mcmd, input logic [63:0] e_maddr);
        vec_t v;
        v.cmd = cmd;       v.addr = addr;       v.en = en;
        v.mresp = mresp;   v.mtag = mtag;       v.mdata = mdata;
        v.e_resp = e_resp; v.e_ptag = e_ptag;   v.e_pdata = e_pdata;
        v.e_mcmd = e_mcmd; v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, sample outputs 1ns later.
    task automatic apply(input string nm, input logic r, input vec_t v);
        @(negedge clk);
        rst = r;
        bus.proc2cache_command_i = v.cmd;
        bus.proc2cache_addr_i    = v.addr;
        bus.memory_enable_i      = v.en;
        bus.mem2cache_response_i = v.mresp;
        bus.mem2cache_tag_i      = v.mtag;
        bus.mem2cache_data_i     = v.mdata;
        #1;
        check({nm, " resp"},  64'(bus.cache2proc_response_o), 64'(v.e_resp));
        check({nm, " ptag"},  64'(bus.cache2proc_tag_o),      64'(v.e_ptag));
        check({nm, " pdata"}, bus.cache2proc_data_o,          v.e_pdata);
        check({nm, " mcmd"},  64'(bus.cache2mem_command_o),   64'(v.e_mcmd));
        check({nm, " maddr"}, bus.cache2mem_addr_o,           v.e_maddr);
    endtask

    initial begin
        bus.proc2cache_command_i = NO;
        bus.proc2cache_addr_i    = '0;
        bus.memory_enable_i      = 1'b0;
        bus.mem2cache_response_i = '0;
        bus.mem2cache_tag_i      = '0;
        bus.mem2cache_data_i     = '0;

        // cold miss, hit after fill, conflict eviction, same-cycle fill vs lookup, stale fill
        vecs.push_back(mk(ST, 64'h40,  1, 0, 0, 0,                     0, 0, 0,                     0, 0));
        vecs.push_back(mk(LD, 64'h40,  0, 0, 0, 0,                     1, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 3, 0, 0,                     0, 0, 0,                     1, 64'h40));
        vecs.push_back(mk(NO, 0,       1, 0, 0, 0,                     0, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 0, 3, 64'hDEAD_BEEF,         0, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 0, 0, 0,                     0, 1, 64'hDEAD_BEEF,         0, 0));
        vecs.push_back(mk(LD, 64'h44,  1, 0, 0, 0,                     1, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 0, 0, 0,                     0, 1, 64'hDEAD_BEEF,         0, 0));
        vecs.push_back(mk(NO, 0,       1, 0, 0, 0,                     0, 0, 0,                     0, 0));
        vecs.push_back(mk(LD, 64'h140, 1, 0, 0, 0,                     1, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 7, 0, 0,                     0, 0, 0,                     1, 64'h140));
        vecs.push_back(mk(NO, 0,       1, 0, 7, 64'h1111_2222_3333_4444, 0, 0, 0,                   0, 0));
        vecs.push_back(mk(LD, 64'h40,  0, 0, 0, 0,                     2, 1, 64'h1111_2222_3333_4444, 0, 0));
        vecs.push_back(mk(NO, 0,       1, 2, 0, 0,                     0, 0, 0,                     1, 64'h40));
        vecs.push_back(mk(LD, 64'h40,  0, 0, 2, 64'hAAAA,              1, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 4, 0, 0,                     0, 2, 64'hAAAA,              1, 64'h40));
        vecs.push_back(mk(NO, 0,       0, 0, 4, 64'hBBBB,              0, 0, 0,                     0, 0));
        vecs.push_back(mk(LD, 64'h40,  0, 0, 0, 0,                     2, 1, 64'hBBBB,              0, 0));
        vecs.push_back(mk(NO, 0,       0, 0, 0, 0,                     0, 2, 64'hBBBB,              0, 0));
        vecs.push_back(mk(NO, 0,       0, 0, 9, 64'hCC,                0, 0, 0,                     0, 0));
        vecs.push_back(mk(NO, 0,       1, 0, 0, 0,                     0, 0, 0,                     0, 0));
        // fill the MSHR file with memory disabled, then one more load is refused
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(LD, 64'h1000 + 64'(8 * k), 0, 0, 0, 0, 4'(k + 1), 0, 0, 0, 0));
        vecs.push_back(mk(LD, 64'h2000, 0, 0, 0, 0,                    0, 0, 0,                     0, 0));

        apply("rst0", 1'b1, mk(LD, 64'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("rst1", 1'b1, mk(LD, 64'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("rel",  1'b0, mk(NO, 0,      1, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), 1'b0, vecs[i]);

        // back-pressure: request for 0x1000 held until memory accepts on the 4th cycle
        for (int c = 0; c < 4; c++)
            apply($sformatf("bp%0d", c), 1'b0, mk(LD, 64'h2000, 1, (c == 3) ? 4'd5 : 4'd0, 0, 0, 0, 0, 0, 1, 64'h1000));
        apply("bp_next", 1'b0, mk(NO, 0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h1008));

        // reset with entry 1 waiting on mem tag 5; the late fill must be dropped
        apply("mrst0",  1'b1, mk(LD, 64'h3000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("mrst1",  1'b1, mk(LD, 64'h3000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("mrel",   1'b0, mk(NO, 0,        1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("stale",  1'b0, mk(NO, 0,        1, 0, 5, 64'h5555, 0, 0, 0, 0, 0));
        apply("stale1", 1'b0, mk(NO, 0,        1, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("reload", 1'b0, mk(LD, 64'h1000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        apply("remiss", 1'b0, mk(NO, 0,        1, 6, 0, 0, 0, 0, 0, 1, 64'h1000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
